// File: rtl/mips_writeback_if.sv
// mips_writeback_if
// Bundles the signals between execute/data-memory, the writeback stage and the
// decode-stage register-file write port.
//   master : the execute/memory side; drives the retiring instruction and load data,
//            observes in_ready and the register-file write port.
//   slave  : the writeback stage itself.
// Signals:
//   in_valid, in_ready          retiring-instruction handshake
//   instruction, alu_result     retiring instruction word and execute result
//   reg_dst, reg_wr, mem_to_reg control bits from decode
//   mem_rdata, mem_rvalid       load data from data memory
//   write_data, write_register, reg_wr_out   register-file write port
//   retired_count, mem_timeout  status outputs
interface mips_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic        reg_dst;
    logic        reg_wr;
    logic        mem_to_reg;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] write_data;
    logic [4:0]  write_register;
    logic        reg_wr_out;
    logic [15:0] retired_count;
    logic        mem_timeout;

    modport master (
        output in_valid, instruction, alu_result, reg_dst, reg_wr, mem_to_reg,
               mem_rdata, mem_rvalid,
        input  in_ready, write_data, write_register, reg_wr_out, retired_count,
               mem_timeout
    );

    modport slave (
        input  in_valid, instruction, alu_result, reg_dst, reg_wr, mem_to_reg,
               mem_rdata, mem_rvalid,
        output in_ready, write_data, write_register, reg_wr_out, retired_count,
               mem_timeout
    );
endinterface

// File: rtl/mips_writeback.sv
// mips_writeback
// Writeback stage of the multicycle MIPS datapath. Accepts one retiring
// instruction at a time, waits for load data when needed (bounded by
// MEM_TIMEOUT cycles), and drives one registered register-file write per
// instruction. Also counts retired instructions and flags abandoned loads.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mips_writeback_if.slave (handshake, instruction, load data,
//          register-file write port, retired_count, mem_timeout)
// Parameters:
//   MEM_TIMEOUT  cycles allowed in WAIT_MEM before a load is abandoned (1..255)
module mips_writeback #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clock,
    input logic              reset,
    mips_writeback_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        COMMIT
    } state_t;

    // Counter value on the last permitted wait cycle; the counter starts at 0
    // on the first WAIT_MEM cycle, so this gives exactly MEM_TIMEOUT cycles.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  timeout_cnt_q;
    logic        wr_latched_q;
    logic [31:0] write_data_q;
    logic [4:0]  write_register_q;
    logic        reg_wr_out_q;
    logic [15:0] retired_count_q;
    logic        mem_timeout_q;

    logic        accepting;
    logic        is_load;
    logic        wait_expired;
    logic [4:0]  dest;

    assign accepting    = bus.in_valid && (state_q != WAIT_MEM);
    assign is_load      = bus.reg_wr && bus.mem_to_reg;
    assign wait_expired = (timeout_cnt_q == LAST_WAIT);
    assign dest         = bus.reg_dst ? bus.instruction[15:11] : bus.instruction[20:16];

    // in_ready depends on state only, so execute never sees a path from its
    // own valid back into ready.
    assign bus.in_ready       = (state_q != WAIT_MEM);
    assign bus.write_data     = write_data_q;
    assign bus.write_register = write_register_q;
    assign bus.reg_wr_out     = reg_wr_out_q;
    assign bus.retired_count  = retired_count_q;
    assign bus.mem_timeout    = mem_timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COMMIT: begin
                if (bus.in_valid) begin
                    state_d = is_load ? WAIT_MEM : COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                // Data arriving on the expiry edge still wins over the timeout.
                if (bus.mem_rvalid || wait_expired) begin
                    state_d = COMMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The write strobe is computed on the edge that enters COMMIT, so the
    // register-file port is fully registered and valid for the whole commit
    // cycle. A timed-out load simply never raises the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_cnt_q    <= '0;
            wr_latched_q     <= 1'b0;
            write_data_q     <= '0;
            write_register_q <= '0;
            reg_wr_out_q     <= 1'b0;
            retired_count_q  <= '0;
            mem_timeout_q    <= 1'b0;
        end else begin
            reg_wr_out_q <= 1'b0;
            case (state_q)
                IDLE, COMMIT: begin
                    if (accepting) begin
                        write_register_q <= dest;
                        wr_latched_q     <= bus.reg_wr;
                        if (is_load) begin
                            timeout_cnt_q <= '0;
                        end else begin
                            write_data_q <= bus.alu_result;
                            reg_wr_out_q <= bus.reg_wr && (dest != 5'd0);
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        write_data_q <= bus.mem_rdata;
                        reg_wr_out_q <= wr_latched_q && (write_register_q != 5'd0);
                    end else if (wait_expired) begin
                        mem_timeout_q <= 1'b1;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
            // Counting on entry to COMMIT makes the count include the
            // instruction whose write is on the port during its commit cycle.
            if (state_d == COMMIT) begin
                retired_count_q <= retired_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_writeback.sv
// tb_mips_writeback
// Self-checking bench for mips_writeback: directed scenarios followed by
// randomized instruction traffic, compared against a transaction-level model
// of what each retiring instruction should leave on the register-file port.
module tb_mips_writeback;

    localparam int MEM_TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mips_writeback_if bus ();

    mips_writeback #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Expected architectural view of the register-file port.
    logic [31:0] exp_data    = '0;
    logic [4:0]  exp_reg     = '0;
    logic [15:0] exp_count   = '0;
    logic        exp_timeout = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCommit(input logic strobe);
        checkOutput("reg_wr_out",     {31'b0, bus.reg_wr_out},  {31'b0, strobe});
        checkOutput("write_register", {27'b0, bus.write_register}, {27'b0, exp_reg});
        checkOutput("write_data",     bus.write_data,           exp_data);
        checkOutput("retired_count",  {16'b0, bus.retired_count}, {16'b0, exp_count});
        checkOutput("mem_timeout",    {31'b0, bus.mem_timeout}, {31'b0, exp_timeout});
        checkOutput("in_ready_commit", {31'b0, bus.in_ready},   32'd1);
    endtask

    // Noise on every input that should be ignored while no transfer happens.
    task automatic driveNoise();
        bus.in_valid    = 1'b0;
        bus.instruction = $urandom;
        bus.alu_result  = $urandom;
        bus.reg_dst     = 1'($urandom_range(0, 1));
        bus.reg_wr      = 1'($urandom_range(0, 1));
        bus.mem_to_reg  = 1'($urandom_range(0, 1));
        bus.mem_rdata   = $urandom;
        bus.mem_rvalid  = 1'($urandom_range(0, 1));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            driveNoise();
            @(negedge clock);
            checkOutput("reg_wr_out_idle", {31'b0, bus.reg_wr_out}, 32'd0);
            checkOutput("in_ready_idle",   {31'b0, bus.in_ready},   32'd1);
            checkOutput("count_idle",      {16'b0, bus.retired_count}, {16'b0, exp_count});
            checkOutput("data_idle",       bus.write_data, exp_data);
        end
    endtask

    // Presents one instruction at the current negedge (DUT must be ready),
    // supplies load data after 'delay' wait cycles (delay >= MEM_TIMEOUT means
    // never), and checks the resulting commit cycle. Returns at the commit
    // negedge with in_valid still high so the caller can go back-to-back.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] alu,
                                 input logic rd_sel, input logic wr, input logic m2r,
                                 input int delay, input logic [31:0] rdata);
        logic [4:0] dest;
        logic       strobe;
        logic       timed_out;
        checkOutput("in_ready_accept", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid    = 1'b1;
        bus.instruction = instr;
        bus.alu_result  = alu;
        bus.reg_dst     = rd_sel;
        bus.reg_wr      = wr;
        bus.mem_to_reg  = m2r;
        bus.mem_rdata   = $urandom;
        bus.mem_rvalid  = 1'($urandom_range(0, 1));
        dest = rd_sel ? instr[15:11] : instr[20:16];
        @(negedge clock);
        exp_reg   = dest;
        exp_count = exp_count + 16'd1;
        if (wr && m2r) begin
            timed_out = 1'b1;
            for (int i = 0; i < MEM_TIMEOUT; i++) begin
                checkOutput("in_ready_wait",   {31'b0, bus.in_ready},   32'd0);
                checkOutput("reg_wr_out_wait", {31'b0, bus.reg_wr_out}, 32'd0);
                driveNoise();
                bus.mem_rvalid = (i == delay);
                if (i == delay) bus.mem_rdata = rdata;
                @(negedge clock);
                if (i == delay) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            bus.mem_rvalid = 1'b0;
            if (timed_out) begin
                exp_timeout = 1'b1;
                strobe      = 1'b0;
            end else begin
                exp_data = rdata;
                strobe   = (dest != 5'd0);
            end
        end else begin
            exp_data = alu;
            strobe   = wr && (dest != 5'd0);
        end
        checkCommit(strobe);
    endtask

    initial begin
        driveNoise();
        bus.mem_rvalid = 1'b0;
        #12;
        checkOutput("reset_data",  bus.write_data, 32'd0);
        checkOutput("reset_reg",   {27'b0, bus.write_register}, 32'd0);
        checkOutput("reset_strobe", {31'b0, bus.reg_wr_out}, 32'd0);
        checkOutput("reset_count", {16'b0, bus.retired_count}, 32'd0);
        checkOutput("reset_timeout", {31'b0, bus.mem_timeout}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idleCycles(2);

        $display("[TB] directed: ALU write, load, timeout, r0, store");
        applyStimulus(32'h012A4020, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 0, 32'h0);
        idleCycles(1);
        applyStimulus(32'h8D090000, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF);
        idleCycles(1);
        applyStimulus(32'h8D0A0004, 32'h0, 1'b0, 1'b1, 1'b1, 99, 32'h0);
        idleCycles(3);
        applyStimulus(32'h00000020, 32'h0000_0077, 1'b1, 1'b1, 1'b0, 0, 32'h0);
        applyStimulus(32'hAD090000, 32'h0000_0088, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        // Boundary: data arrives on the expiry edge, and on the first wait cycle.
        applyStimulus(32'h8D0B0000, 32'h0, 1'b0, 1'b1, 1'b1, MEM_TIMEOUT - 1, 32'hCAFE0001);
        applyStimulus(32'h8D0C0000, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'hCAFE0002);
        idleCycles(1);

        $display("[TB] back-to-back ALU writes");
        for (int i = 0; i < 8; i++) begin
            applyStimulus({16'h0000, 5'(i + 1), 11'h020}, $urandom, 1'b1, 1'b1, 1'b0, 0, 32'h0);
        end
        idleCycles(1);

        $display("[TB] random traffic");
        for (int t = 0; t < 150; t++) begin
            logic [31:0] instr;
            int          kind;
            int          delay;
            instr = $urandom;
            if ($urandom_range(0, 5) == 0) instr[20:11] = '0;
            kind  = $urandom_range(0, 3);
            delay = $urandom_range(0, MEM_TIMEOUT + 2);
            case (kind)
                0: applyStimulus(instr, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1,
                                 delay, $urandom);
                1: applyStimulus(instr, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                                 0, 32'h0);
                default: applyStimulus(instr, $urandom, 1'($urandom_range(0, 1)), 1'b0,
                                       1'($urandom_range(0, 1)), 0, 32'h0);
            endcase
            idleCycles($urandom_range(0, 2));
        end

        $display("[TB] retired_count wrap");
        idleCycles(1);
        bus.in_valid   = 1'b1;
        bus.reg_wr     = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_rvalid = 1'b0;
        while (exp_count != 16'hFFFF) begin
            bus.alu_result = $urandom;
            exp_data       = bus.alu_result;
            @(negedge clock);
            exp_count = exp_count + 16'd1;
            if (exp_count[11:0] == 12'h000)
                checkOutput("count_ramp", {16'b0, bus.retired_count}, {16'b0, exp_count});
        end
        checkOutput("count_ffff", {16'b0, bus.retired_count}, 32'h0000_FFFF);
        checkOutput("ramp_strobe", {31'b0, bus.reg_wr_out}, 32'd0);
        @(negedge clock);
        exp_count = exp_count + 16'd1;
        checkOutput("count_wrap", {16'b0, bus.retired_count}, 32'd0);
        checkOutput("data_wrap", bus.write_data, exp_data);
        idleCycles(1);

        $display("[TB] reset during WAIT_MEM");
        bus.in_valid    = 1'b1;
        bus.instruction = 32'h8D0D0000;
        bus.reg_dst     = 1'b0;
        bus.reg_wr      = 1'b1;
        bus.mem_to_reg  = 1'b1;
        bus.mem_rvalid  = 1'b0;
        @(negedge clock);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("in_ready_prereset", {31'b0, bus.in_ready}, 32'd0);
            @(negedge clock);
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_data",    bus.write_data, 32'd0);
        checkOutput("rst_reg",     {27'b0, bus.write_register}, 32'd0);
        checkOutput("rst_strobe",  {31'b0, bus.reg_wr_out}, 32'd0);
        checkOutput("rst_count",   {16'b0, bus.retired_count}, 32'd0);
        checkOutput("rst_timeout", {31'b0, bus.mem_timeout}, 32'd0);
        checkOutput("rst_ready",   {31'b0, bus.in_ready}, 32'd1);
        @(negedge clock);
        reset       = 1'b0;
        exp_data    = '0;
        exp_reg     = '0;
        exp_count   = '0;
        exp_timeout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid   = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            @(negedge clock);
            checkOutput("post_rst_strobe", {31'b0, bus.reg_wr_out}, 32'd0);
            checkOutput("post_rst_count",  {16'b0, bus.retired_count}, 32'd0);
            checkOutput("post_rst_data",   bus.write_data, 32'd0);
        end
        bus.mem_rvalid = 1'b0;
        applyStimulus(32'h012A4020, 32'h0000_0042, 1'b1, 1'b1, 1'b0, 0, 32'h0);
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_writeback.md
# mips_writeback

Writeback stage of the single-cycle-to-multicycle MIPS datapath. It accepts one retiring instruction at a time from execute, waits for load data from the data memory when required, and drives the register-file write port of the decode stage with one write strobe, data and 5-bit destination per instruction. It also counts retired instructions and flags data-memory timeouts.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in WAIT_MEM before the load is abandoned; legal range 1..255.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents a retiring instruction
- in_ready  out  1  writeback can accept; transfer when in_valid && in_ready at rising edge
- instruction  in  32  retiring instruction word; rd = [15:11], rt = [20:16]
- alu_result  in  32  execute result
- reg_dst  in  1  1: destination rd, 0: destination rt
- reg_wr  in  1  instruction writes a register
- mem_to_reg  in  1  write data comes from memory (load)
- mem_rdata  in  32  load data
- mem_rvalid  in  1  mem_rdata valid this cycle
- write_data  out  32  register-file write data
- write_register  out  5  register-file write address
- reg_wr_out  out  1  register-file write strobe, one cycle per committed write
- retired_count  out  16  instructions committed since reset
- mem_timeout  out  1  sticky: a load was abandoned

## Operation
- Reset (async, immediate): state IDLE; write_data = 0, write_register = 0, reg_wr_out = 0, retired_count = 0, mem_timeout = 0, timeout counter = 0.
- FSM states IDLE, WAIT_MEM, COMMIT.
- in_ready = 1 in IDLE and COMMIT, 0 in WAIT_MEM.
- Accept (IDLE or COMMIT, in_valid = 1): latch destination = reg_dst ? instruction[15:11] : instruction[20:16] into write_register; latch reg_wr.
  - reg_wr && mem_to_reg: go WAIT_MEM, clear timeout counter.
  - otherwise: write_data <= alu_result, go COMMIT.
- IDLE, no in_valid: stay. COMMIT, no in_valid: go IDLE.
- WAIT_MEM:
  - mem_rvalid = 1: write_data <= mem_rdata, go COMMIT.
  - else counter increments; when counter reaches MEM_TIMEOUT - 1 without mem_rvalid: set mem_timeout, mark write suppressed, go COMMIT (write_data unchanged).
  - mem_rvalid on the same edge as expiry: data accepted, no timeout.
- COMMIT: reg_wr_out = latched reg_wr && write_register != 0 && not suppressed. Register 0 is never written. retired_count increments by 1 every COMMIT cycle (writes, non-writes, suppressed loads), wrapping 0xFFFF -> 0x0000.
- reg_wr_out = 0 in every state other than COMMIT. write_data and write_register hold last value outside COMMIT.
- mem_rvalid outside WAIT_MEM is ignored.
- mem_timeout clears only on reset.

## Timing
- All outputs registered; no combinational path from inputs to outputs except in_ready (state-only).
- Non-load: accepted at edge N; reg_wr_out/write_data/write_register valid in cycle after N; decode register file writes at edge N+1.
- Load: mem_rvalid sampled at edge M; commit cycle follows M. Minimum accept-to-commit latency 2 edges.
- Back-to-back non-loads sustain one commit per cycle (accept during COMMIT).
- Timeout: exactly MEM_TIMEOUT cycles in WAIT_MEM, then one COMMIT cycle with reg_wr_out = 0.
- Reset asserted mid-WAIT_MEM or COMMIT: pending write discarded, no strobe after reset deasserts until a new accept.

## Test plan
- Reset then ADD-type: instruction 0x012A4020 (rd=8), reg_dst=1, reg_wr=1, alu_result 0x0000_0005 -> next cycle reg_wr_out=1, write_register=8, write_data=5, retired_count=1.
- Load: reg_dst=0, rt=9, mem_to_reg=1; mem_rvalid with 0xDEADBEEF 3 cycles later -> in_ready=0 during wait, one strobe write_register=9, write_data=0xDEADBEEF.
- Timeout: load, no mem_rvalid, MEM_TIMEOUT=15 -> after 15 wait cycles mem_timeout=1, COMMIT with reg_wr_out=0, retired_count +1; later rvalid ignored.
- Zero register and non-write: destination 0 with reg_wr=1, then store with reg_wr=0 -> reg_wr_out stays 0 both, retired_count +2.
- 8 back-to-back non-loads, in_valid held high -> 8 consecutive strobe cycles, in_ready constantly 1; preload retired_count to 0xFFFF via 65535 commits -> wraps to 0.
- Reset asserted during WAIT_MEM -> all outputs 0 immediately, no strobe after release, rvalid afterward ignored.
